// File: rtl/mult_div_unit_pkg.sv
// Shared CPU parameters for the mult/div unit: MDOp codes next to the ALU op codes, result payload.
package mult_div_unit_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned OP_W   = 3;

    // ALU op codes used by the E-stage decoder
    localparam logic [3:0] ALU_add = 4'd0;
    localparam logic [3:0] ALU_sub = 4'd1;
    localparam logic [3:0] ALU_and = 4'd2;
    localparam logic [3:0] ALU_or  = 4'd3;

    localparam logic [OP_W-1:0] MD_none  = 3'd0;
    localparam logic [OP_W-1:0] MD_mult  = 3'd1;
    localparam logic [OP_W-1:0] MD_multu = 3'd2;
    localparam logic [OP_W-1:0] MD_div   = 3'd3;
    localparam logic [OP_W-1:0] MD_divu  = 3'd4;
    localparam logic [OP_W-1:0] MD_mthi  = 3'd5;
    localparam logic [OP_W-1:0] MD_mtlo  = 3'd6;
    localparam logic [OP_W-1:0] MD_rsvd  = 3'd7;

    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } md_result_t;

    function automatic logic is_long_op(input logic [OP_W-1:0] op);
        return (op >= MD_mult) && (op <= MD_divu);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS-style HI/LO unit: result computed at issue, published after a fixed busy window.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Start,
    input  logic [OP_W-1:0]   MDOp,
    input  logic [DATA_W-1:0] RsData,
    input  logic [DATA_W-1:0] RtData,
    output logic              Busy,
    output logic              MDStall,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

    logic [0:0]        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_busy, w_busy_nxt;
    logic [DATA_W-1:0] r_hi, w_hi_nxt;
    logic [DATA_W-1:0] r_lo, w_lo_nxt;
    md_result_t        r_tmp, w_tmp_nxt;

    logic [2*DATA_W-1:0] w_prod_s, w_prod_u;
    logic                w_neg_a, w_neg_b;
    logic [DATA_W-1:0]   w_abs_a, w_abs_b;
    logic [DATA_W-1:0]   w_sdiv_den, w_udiv_den;
    logic [DATA_W-1:0]   w_uq_mag, w_ur_mag, w_quo_s, w_rem_s, w_quo_u, w_rem_u;
    md_result_t          w_result;

    // Sign-extended operands give the signed product in the low 64 bits
    assign w_prod_s = {{DATA_W{RsData[DATA_W-1]}}, RsData} * {{DATA_W{RtData[DATA_W-1]}}, RtData};
    assign w_prod_u = {{DATA_W{1'b0}}, RsData} * {{DATA_W{1'b0}}, RtData};

    // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow
    assign w_neg_a    = RsData[DATA_W-1];
    assign w_neg_b    = RtData[DATA_W-1];
    assign w_abs_a    = w_neg_a ? (~RsData + DATA_W'(1)) : RsData;
    assign w_abs_b    = w_neg_b ? (~RtData + DATA_W'(1)) : RtData;
    assign w_sdiv_den = (w_abs_b == '0) ? DATA_W'(1) : w_abs_b;
    assign w_udiv_den = (RtData == '0) ? DATA_W'(1) : RtData;
    assign w_uq_mag   = w_abs_a / w_sdiv_den;
    assign w_ur_mag   = w_abs_a % w_sdiv_den;
    assign w_quo_s    = (w_neg_a ^ w_neg_b) ? (~w_uq_mag + DATA_W'(1)) : w_uq_mag;
    assign w_rem_s    = w_neg_a ? (~w_ur_mag + DATA_W'(1)) : w_ur_mag;
    assign w_quo_u    = RsData / w_udiv_den;
    assign w_rem_u    = RsData % w_udiv_den;

    // Divide by zero republishes the current HI/LO, which cannot change during RUN
    always_comb begin
        w_result.hi = r_hi;
        w_result.lo = r_lo;
        case (MDOp)
            MD_mult:  w_result = w_prod_s;
            MD_multu: w_result = w_prod_u;
            MD_div:   if (RtData != '0) w_result = {w_rem_s, w_quo_s};
            MD_divu:  if (RtData != '0) w_result = {w_rem_u, w_quo_u};
            default:  ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_tmp_nxt   = r_tmp;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    case (MDOp)
                        MD_mult, MD_multu, MD_div, MD_divu: begin
                            w_tmp_nxt   = w_result;
                            w_cnt_nxt   = (MDOp == MD_mult || MDOp == MD_multu) ? CNT_MULT : CNT_DIV;
                            w_busy_nxt  = 1'b1;
                            w_state_nxt = S_RUN;
                        end
                        MD_mthi: w_hi_nxt = RsData;
                        MD_mtlo: w_lo_nxt = RsData;
                        MD_none, MD_rsvd: ;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_hi_nxt    = r_tmp.hi;
                    w_lo_nxt    = r_tmp.lo;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_tmp   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_tmp   <= w_tmp_nxt;
        end
    end

    assign Busy    = r_busy;
    assign HI      = r_hi;
    assign LO      = r_lo;
    assign MDStall = r_busy | (Start & is_long_op(MDOp));

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random ops against an arithmetic model.
module tb_mult_div_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] RsData;
    logic [31:0] RtData;
    logic        Busy;
    logic        MDStall;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks;
    int failures;

    logic [31:0] m_hi, m_lo;

    mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp),
        .RsData(RsData), .RtData(RtData), .Busy(Busy), .MDStall(MDStall),
        .HI(HI), .LO(LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural meaning of each op in plain arithmetic
    task automatic model_step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] hi_in, input logic [31:0] lo_in,
                              output logic [31:0] hi_out, output logic [31:0] lo_out);
        longint      sp;
        logic [63:0] up;
        int          sa, sb;
        hi_out = hi_in;
        lo_out = lo_in;
        case (op)
            3'd1: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                up = sp;
                hi_out = up[63:32];
                lo_out = up[31:0];
            end
            3'd2: begin
                up = {32'd0, a} * {32'd0, b};
                hi_out = up[63:32];
                lo_out = up[31:0];
            end
            3'd3: begin
                if (b == 32'd0) begin
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo_out = 32'h8000_0000;
                    hi_out = 32'd0;
                end else begin
                    sa = a;
                    sb = b;
                    lo_out = sa / sb;
                    hi_out = sa % sb;
                end
            end
            3'd4: begin
                if (b != 32'd0) begin
                    lo_out = a / b;
                    hi_out = a % b;
                end
            end
            3'd5: hi_out = a;
            3'd6: lo_out = a;
            default: ;
        endcase
    endtask

    // Issue a long op; report busy length, HI/LO stability during busy, final HI/LO
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit inject_mid, output int busy_cycles, output bit stable,
                          output bit stall_seen, output logic [31:0] hi, output logic [31:0] lo);
        logic [31:0] hi0, lo0;
        @(negedge clk);
        Start = 1'b1; MDOp = op; RsData = a; RtData = b;
        #1 stall_seen = MDStall;
        @(negedge clk);
        Start = 1'b0; MDOp = 3'd0;
        hi0 = HI; lo0 = LO;
        stable = 1'b1;
        busy_cycles = 0;
        while (Busy === 1'b1 && busy_cycles < 40) begin
            busy_cycles++;
            if (HI !== hi0 || LO !== lo0 || MDStall !== 1'b1) stable = 1'b0;
            if (inject_mid && busy_cycles == 3) begin
                Start = 1'b1; MDOp = 3'd5; RsData = 32'hDEAD_BEEF; RtData = 32'd0;
            end else if (inject_mid && busy_cycles == 4) begin
                Start = 1'b1; MDOp = 3'd1; RsData = 32'd9; RtData = 32'd9;
            end else begin
                Start = 1'b0; MDOp = 3'd0;
            end
            @(negedge clk);
        end
        Start = 1'b0; MDOp = 3'd0;
        hi = HI; lo = LO;
    endtask

    task automatic do_reset();
        Start = 1'b0; MDOp = 3'd0; RsData = '0; RtData = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        do_reset();
        checks++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || MDStall !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: Busy=%b MDStall=%b HI=%h LO=%h, want 0/0/0/0", Busy, MDStall, HI, LO);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  ops [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd3};
        logic [31:0] as  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
        logic [31:0] bs  [5] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'hFFFF_FFFF};
        logic [31:0] ehi [5] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd1, 32'd0};
        logic [31:0] elo [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd3, 32'h8000_0000};
        int bc, en; bit st, sl; logic [31:0] h, l;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], bs[i], 1'b0, bc, st, sl, h, l);
            en = (ops[i] <= 3'd2) ? MULT_N : DIV_N;
            checks++;
            if (bc != en || !st || !sl || h !== ehi[i] || l !== elo[i]) begin
                failures++;
                $display("FAIL directed_%0d: busy=%0d stable=%0b stall=%0b HI=%h LO=%h, want busy=%0d stable=1 stall=1 HI=%h LO=%h",
                         i, bc, st, sl, h, l, en, ehi[i], elo[i]);
            end
        end
        m_hi = h; m_lo = l;
    endtask

    task automatic test_move();
        @(negedge clk);
        Start = 1'b1; MDOp = 3'd5; RsData = 32'h1234_5678;
        #1;
        checks++;
        if (MDStall !== 1'b0) begin
            failures++;
            $display("FAIL mthi_stall: MDStall=%b want 0", MDStall);
        end
        @(negedge clk);
        checks++;
        if (HI !== 32'h1234_5678 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL mthi_write: HI=%h Busy=%b want 12345678/0", HI, Busy);
        end
        MDOp = 3'd6; RsData = 32'h9ABC_DEF0;
        @(negedge clk);
        Start = 1'b0; MDOp = 3'd0;
        checks++;
        if (LO !== 32'h9ABC_DEF0 || HI !== 32'h1234_5678 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL mtlo_write: HI=%h LO=%h Busy=%b want 12345678/9abcdef0/0", HI, LO, Busy);
        end
        m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;
    endtask

    task automatic test_none_ops();
        logic [2:0] codes [2] = '{3'd0, 3'd7};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            Start = 1'b1; MDOp = codes[i]; RsData = 32'h5555_AAAA; RtData = 32'd3;
            #1;
            checks++;
            if (MDStall !== 1'b0) begin
                failures++;
                $display("FAIL noop_stall_%0d: MDStall=%b want 0", codes[i], MDStall);
            end
            @(negedge clk);
            Start = 1'b0;
            checks++;
            if (Busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
                failures++;
                $display("FAIL noop_%0d: Busy=%b HI=%h LO=%h want 0/%h/%h", codes[i], Busy, HI, LO, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_div_zero();
        int bc; bit st, sl; logic [31:0] h, l;
        @(negedge clk);
        Start = 1'b1; MDOp = 3'd5; RsData = 32'hA;
        @(negedge clk);
        MDOp = 3'd6; RsData = 32'hB;
        @(negedge clk);
        Start = 1'b0;
        run_op(3'd3, 32'd100, 32'd0, 1'b1, bc, st, sl, h, l);
        checks++;
        if (bc != DIV_N || !st || h !== 32'hA || l !== 32'hB) begin
            failures++;
            $display("FAIL div_zero: busy=%0d stable=%0b HI=%h LO=%h want %0d/1/a/b", bc, st, h, l, DIV_N);
        end
        @(negedge clk);
        checks++;
        if (Busy !== 1'b0 || HI !== 32'hA) begin
            failures++;
            $display("FAIL midrun_ignored: Busy=%b HI=%h want 0/a", Busy, HI);
        end
        m_hi = 32'hA; m_lo = 32'hB;
    endtask

    task automatic test_reset_mid_run();
        int bc; bit st, sl; logic [31:0] h, l;
        @(negedge clk);
        Start = 1'b1; MDOp = 3'd1; RsData = 32'h7; RtData = 32'h6;
        @(negedge clk);
        Start = 1'b0; MDOp = 3'd0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_run: Busy=%b HI=%h LO=%h want 0/0/0", Busy, HI, LO);
        end
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        run_op(3'd2, 32'd3, 32'd4, 1'b0, bc, st, sl, h, l);
        checks++;
        if (bc != MULT_N || h !== 32'd0 || l !== 32'd12) begin
            failures++;
            $display("FAIL after_reset_multu: busy=%0d HI=%h LO=%h want %0d/0/c", bc, h, l, MULT_N);
        end
        m_hi = 32'd0; m_lo = 32'd12;
    endtask

    task automatic test_random();
        logic [2:0] op; logic [31:0] a, b, eh, el, h, l;
        int bc, en; bit st, sl;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(1, 6));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 17));
                2: b = -32'($urandom_range(1, 17));
                default: b = $urandom;
            endcase
            model_step(op, a, b, m_hi, m_lo, eh, el);
            if (op <= 3'd4) begin
                run_op(op, a, b, 1'b0, bc, st, sl, h, l);
                en = (op <= 3'd2) ? MULT_N : DIV_N;
                checks++;
                if (bc != en || !st || !sl || h !== eh || l !== el) begin
                    failures++;
                    $display("FAIL random_%0d op=%0d a=%h b=%h: busy=%0d stable=%0b stall=%0b HI=%h LO=%h want busy=%0d HI=%h LO=%h",
                             i, op, a, b, bc, st, sl, h, l, en, eh, el);
                end
            end else begin
                @(negedge clk);
                Start = 1'b1; MDOp = op; RsData = a; RtData = b;
                @(negedge clk);
                Start = 1'b0; MDOp = 3'd0;
                checks++;
                if (Busy !== 1'b0 || HI !== eh || LO !== el) begin
                    failures++;
                    $display("FAIL random_move_%0d op=%0d: Busy=%b HI=%h LO=%h want 0/%h/%h", i, op, Busy, HI, LO, eh, el);
                end
            end
            m_hi = eh; m_lo = el;
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        Start = 1'b0; MDOp = 3'd0; RsData = '0; RtData = '0;
        test_reset();
        test_directed();
        test_move();
        test_none_ops();
        test_div_zero();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
